// File: rtl/gci_std_display_timing_generator_param.sv
// Parametrised display timing generator: H/V sync, active-area blank/enable,
// leading pixel data request, frame-start sync, pixel position and frame count.
// Optional vertical-blank interrupt, enabled by defining GCI_STD_DISPLAY_TIMING_IRQ_EN.
// All outputs are registered and reflect the (h,v) counter state of the previous cycle.
module gci_std_display_timing_generator_param #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  // Must not exceed H_BP, so a request never wraps more than one line ahead.
  parameter int unsigned REQ_LEAD = 2,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iIRQ_ACK,
  output logic             oDATA_REQ,
  output logic             oDATA_SYNC,
  output logic             onDISP_RESET,
  output logic             oDISP_ENA,
  output logic             oDISP_BLANK,
  output logic             oDISP_HSYNC,
  output logic             oDISP_VSYNC,
  output logic [CNT_W-1:0] oPIXEL_X,
  output logic [CNT_W-1:0] oPIXEL_Y,
  output logic [15:0]      oFRAME_CNT,
  output logic             oIRQ
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W:0]   REQ_LEAD_W = (CNT_W + 1)'(REQ_LEAD);
  localparam logic [CNT_W:0]   H_TOTAL_W  = (CNT_W + 1)'(H_TOTAL);

  // Raster position
  logic [CNT_W-1:0] hCnt, vCnt;
  logic [CNT_W-1:0] hNext, vNext;
  logic             hLast, vLast;

  // Decoded position attributes
  logic             activeArea;
  logic             hSyncAct, vSyncAct;
  logic [CNT_W:0]   reqSum;
  logic [CNT_W-1:0] reqH, reqV;
  logic             reqActive, reqFirst;

  // Output registers
  logic             dataReq, dataSync, dispBlank, hSync, vSync, dispUp;
  logic [CNT_W-1:0] pixelX, pixelY;
  logic [15:0]      frameCnt;

  // Counter next state: wrap h at line end, v at frame end, restart on iRESET_SYNC
  always_comb begin
    hLast = (hCnt == H_LAST);
    vLast = (vCnt == V_LAST);
    hNext = hCnt + CNT_W'(1);
    vNext = vCnt;
    if (iRESET_SYNC) begin
      hNext = '0;
      vNext = '0;
    end else if (hLast) begin
      hNext = '0;
      vNext = vLast ? '0 : vCnt + CNT_W'(1);
    end
  end

  // Decode the current position and the position the fetch request targets
  always_comb begin
    activeArea = (hCnt < H_ACT) && (vCnt < V_ACT);
    hSyncAct   = (hCnt >= H_SYNC_BEG) && (hCnt < H_SYNC_END);
    vSyncAct   = (vCnt >= V_SYNC_BEG) && (vCnt < V_SYNC_END);
    reqSum     = {1'b0, hCnt} + REQ_LEAD_W;
    if (reqSum >= H_TOTAL_W) begin
      // Request runs into the next line (or the next frame's first line)
      reqH = CNT_W'(reqSum - H_TOTAL_W);
      reqV = vLast ? '0 : vCnt + CNT_W'(1);
    end else begin
      reqH = reqSum[CNT_W-1:0];
      reqV = vCnt;
    end
    reqActive = (reqH < H_ACT) && (reqV < V_ACT);
    reqFirst  = reqActive && (reqH == '0) && (reqV == '0);
  end

  // Raster counters
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      hCnt <= '0;
      vCnt <= '0;
    end else begin
      hCnt <= hNext;
      vCnt <= vNext;
    end
  end

  // Registered video outputs; forced idle while a restart is requested
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      dataReq   <= 1'b0;
      dataSync  <= 1'b0;
      dispBlank <= 1'b0;
      hSync     <= ~SYNC_POL;
      vSync     <= ~SYNC_POL;
      pixelX    <= '0;
      pixelY    <= '0;
    end else if (iRESET_SYNC) begin
      dataReq   <= 1'b0;
      dataSync  <= 1'b0;
      dispBlank <= 1'b0;
      hSync     <= ~SYNC_POL;
      vSync     <= ~SYNC_POL;
      pixelX    <= '0;
      pixelY    <= '0;
    end else begin
      dataReq   <= reqActive;
      dataSync  <= reqFirst;
      dispBlank <= activeArea;
      hSync     <= hSyncAct ? SYNC_POL : ~SYNC_POL;
      vSync     <= vSyncAct ? SYNC_POL : ~SYNC_POL;
      pixelX    <= activeArea ? hCnt : '0;
      pixelY    <= activeArea ? vCnt : '0;
    end
  end

  // Display reset release / enable: set on the first clock after reset, then held
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      dispUp <= 1'b0;
    end else begin
      dispUp <= 1'b1;
    end
  end

  // Completed-frame counter; a restart discards the frame in progress
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      frameCnt <= '0;
    end else if (!iRESET_SYNC && hLast && vLast) begin
      frameCnt <= frameCnt + 16'd1;
    end
  end

`ifdef GCI_STD_DISPLAY_TIMING_IRQ_EN
  logic irqFlag;
  logic irqSet;

  assign irqSet = (hCnt == '0) && (vCnt == V_ACT);

  // Vertical-blank interrupt: set wins over a coincident acknowledge
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      irqFlag <= 1'b0;
    end else begin
      irqFlag <= irqSet | (irqFlag & ~iIRQ_ACK);
    end
  end

  assign oIRQ = irqFlag;
`else
  logic unusedIrqAck;

  assign unusedIrqAck = iIRQ_ACK;
  assign oIRQ         = 1'b0;
`endif

  assign oDATA_REQ    = dataReq;
  assign oDATA_SYNC   = dataSync;
  assign onDISP_RESET = dispUp;
  assign oDISP_ENA    = dispUp;
  assign oDISP_BLANK  = dispBlank;
  assign oDISP_HSYNC  = hSync;
  assign oDISP_VSYNC  = vSync;
  assign oPIXEL_X     = pixelX;
  assign oPIXEL_Y     = pixelY;
  assign oFRAME_CNT   = frameCnt;

endmodule

// File: tb/tb_gci_std_display_timing_generator_param.sv
// Bench for gci_std_display_timing_generator_param with small raster parameters.
// Two instances differ only in sync polarity; both are checked every cycle
// against a frame-index reference model.
module tb_gci_std_display_timing_generator_param;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LEAD = 2;
  localparam int HT = HA + HF + HS + HB;  // 14
  localparam int VT = VA + VF + VS + VB;  // 7
  localparam int FT = HT * VT;            // 98

  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  logic iRESET_SYNC = 1'b0;
  logic iIRQ_ACK = 1'b0;

  logic        reqA, syncA, nrstA, enaA, blankA, hsA, vsA, irqA;
  logic [11:0] xA, yA;
  logic [15:0] frameA;
  logic        reqB, syncB, nrstB, enaB, blankB, hsB, vsB, irqB;
  logic [11:0] xB, yB;
  logic [15:0] frameB;

  gci_std_display_timing_generator_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .REQ_LEAD(LEAD), .SYNC_POL(1'b0), .CNT_W(12)
  ) dutA (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .iIRQ_ACK(iIRQ_ACK),
    .oDATA_REQ(reqA), .oDATA_SYNC(syncA), .onDISP_RESET(nrstA), .oDISP_ENA(enaA),
    .oDISP_BLANK(blankA), .oDISP_HSYNC(hsA), .oDISP_VSYNC(vsA),
    .oPIXEL_X(xA), .oPIXEL_Y(yA), .oFRAME_CNT(frameA), .oIRQ(irqA)
  );

  gci_std_display_timing_generator_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .REQ_LEAD(LEAD), .SYNC_POL(1'b1), .CNT_W(12)
  ) dutB (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .iIRQ_ACK(iIRQ_ACK),
    .oDATA_REQ(reqB), .oDATA_SYNC(syncB), .onDISP_RESET(nrstB), .oDISP_ENA(enaB),
    .oDISP_BLANK(blankB), .oDISP_HSYNC(hsB), .oDISP_VSYNC(vsB),
    .oPIXEL_X(xB), .oPIXEL_Y(yB), .oFRAME_CNT(frameB), .oIRQ(irqB)
  );

  always #5 iCLOCK = ~iCLOCK;

  int nCmp = 0;
  int nBad = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raster position as a linear index into the frame
  int         mh, mv;
  logic [15:0] mFrame;
  logic       eReq, eSync, eBlank, eHsAct, eVsAct, eEna, eIrq;
  int         eX, eY;

  function automatic logic isActive(input int idx);
    return ((idx % HT) < HA) && ((idx / HT) < VA);
  endfunction

  task automatic modelReset();
    mh = 0; mv = 0; mFrame = 16'd0;
    eReq = 0; eSync = 0; eBlank = 0; eHsAct = 0; eVsAct = 0; eEna = 0; eIrq = 0;
    eX = 0; eY = 0;
  endtask

  task automatic modelEdge();
    int n, t;
    if (!inRESET) return;
    n = mv * HT + mh;
    eEna = 1'b1;
`ifdef GCI_STD_DISPLAY_TIMING_IRQ_EN
    if (mh == 0 && mv == VA) eIrq = 1'b1;
    else if (iIRQ_ACK) eIrq = 1'b0;
`endif
    if (iRESET_SYNC) begin
      eReq = 0; eSync = 0; eBlank = 0; eHsAct = 0; eVsAct = 0; eX = 0; eY = 0;
      mh = 0; mv = 0;
    end else begin
      t = (n + LEAD) % FT;
      eReq   = isActive(t);
      eSync  = eReq && (t == 0);
      eBlank = isActive(n);
      eX     = eBlank ? mh : 0;
      eY     = eBlank ? mv : 0;
      eHsAct = (mh >= HA + HF) && (mh < HA + HF + HS);
      eVsAct = (mv >= VA + VF) && (mv < VA + VF + VS);
      if (n == FT - 1) mFrame = mFrame + 16'd1;
      n  = (n + 1) % FT;
      mh = n % HT;
      mv = n / HT;
    end
  endtask

  task automatic compareAll();
    checkVal("flagsA", {reqA, syncA, nrstA, enaA, blankA, hsA, vsA, irqA},
             {eReq, eSync, eEna, eEna, eBlank, ~eHsAct, ~eVsAct, eIrq});
    checkVal("flagsB", {reqB, syncB, nrstB, enaB, blankB, hsB, vsB, irqB},
             {eReq, eSync, eEna, eEna, eBlank, eHsAct, eVsAct, eIrq});
    checkVal("pixelX", xA, eX);
    checkVal("pixelY", yA, eY);
    checkVal("frameA", frameA, mFrame);
    checkVal("pixB", {xB, yB, frameB}, {eX[11:0], eY[11:0], mFrame});
  endtask

  task automatic step(input logic rs, input logic ack);
    iRESET_SYNC = rs;
    iIRQ_ACK    = ack;
    @(posedge iCLOCK);
    modelEdge();
    @(negedge iCLOCK);
    compareAll();
  endtask

  // Advance until the model's pre-edge position is (h,v); bounded
  task automatic advanceTo(input string tag, input int h, input int v);
    int guard = 0;
    while (!(mh == h && mv == v) && guard < 2 * FT) begin
      step(1'b0, 1'b0);
      guard++;
    end
    checkVal(tag, (mh == h && mv == v), 1);
  endtask

  int syncs;

  initial begin
    modelReset();
    // Reset values while inRESET is held low
    repeat (3) begin
      @(negedge iCLOCK);
      compareAll();
    end
    inRESET = 1'b1;

    // Three clean frames
    repeat (3 * FT) step(1'b0, 1'b0);
    checkVal("frames3", frameA, 3);

    // Frame counter wrap from 0xFFFF
    advanceTo("reachWrap", HT - 1, VT - 1);
    force dutA.frameCnt = 16'hFFFF;
    force dutB.frameCnt = 16'hFFFF;
    #1;
    release dutA.frameCnt;
    release dutB.frameCnt;
    mFrame = 16'hFFFF;
    step(1'b0, 1'b0);
    checkVal("wrap", frameA, 0);

    // Synchronous restart mid-line 2
    advanceTo("reachLine2", 4, 2);
    step(1'b1, 1'b0);
    checkVal("restartIdle", {reqA, blankA, hsA, vsA}, 4'b0011);
    syncs = 0;
    repeat (FT - LEAD) begin
      step(1'b0, 1'b0);
      syncs += int'(syncA);
    end
    checkVal("noSyncAfterRestart", syncs, 0);
    syncs = 0;
    repeat (FT) begin
      step(1'b0, 1'b0);
      syncs += int'(syncA);
    end
    checkVal("syncNextFrame", syncs, 1);

    // Random restarts and acknowledges
    repeat (1500) step($urandom_range(0, 99) < 2, $urandom_range(0, 2) == 0);

    // Interrupt: coincident set and ack keeps it set, a lone ack clears it
    repeat (FT) step(1'b0, 1'b0);
    advanceTo("reachIrq", 0, VA);
    step(1'b0, 1'b1);
`ifdef GCI_STD_DISPLAY_TIMING_IRQ_EN
    checkVal("irqSetAck", irqA, 1);
`endif
    step(1'b0, 1'b1);
`ifdef GCI_STD_DISPLAY_TIMING_IRQ_EN
    checkVal("irqAck", irqA, 0);
`else
    checkVal("irqOff", irqA, 0);
`endif

    // Asynchronous reset mid-frame
    repeat ($urandom_range(10, 60)) step(1'b0, 1'b0);
    inRESET = 1'b0;
    #1;
    modelReset();
    compareAll();
    repeat (3) step(1'b0, 1'b0);
    inRESET = 1'b1;
    repeat (FT + 5) step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
